// File: rtl/frame_deser_pkg.sv
// frame_deser_pkg: shared types and constants for the frame deserializer.
// Optional statistics outputs are enabled with FRAME_DESER_STATS_EN (see top).
package frame_deser_pkg;

   // Receive FSM states.
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } state_t;

   // Default sync word, transmitted MSB first.
   localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hD5;

   // Width of the saturating statistics counters.
   localparam int STATS_W = 16;

   // Bits needed for a counter holding 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_deserializer_sync_detector.sv
// sync_detector: sliding-window comparator for the frame sync word.
// The window is the previous SYNC_W-1 bits plus the bit on the input, so a
// match is flagged on the same edge that samples the last sync bit. Only the
// history bits need storage; requires SYNC_W >= 2.
module sync_detector
   import frame_deser_pkg::*;
#(
   parameter int                SYNC_W       = 8,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEFAULT_SYNC_PATTERN)
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clear_i,
   input  logic bit_i,
   output logic match_o
);

   logic [SYNC_W-2:0] hist_q;
   logic [SYNC_W-1:0] window;

   assign window  = {hist_q, bit_i};
   assign match_o = (window == SYNC_PATTERN);

   // Shift every cycle so overlapping candidates are all examined; clear drops stale history.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         hist_q <= '0;
      end else if (clear_i) begin
         hist_q <= '0;
      end else begin
         hist_q <= window[SYNC_W-2:0];
      end
   end

endmodule

// File: rtl/frame_deserializer.sv
// frame_deserializer: hunts a sync word in the descrambled bit stream, then
// assembles FRAME_LEN payload words of DATA_W bits per frame with a flywheel
// that tolerates MISS_MAX-1 consecutive corrupted sync words.
// Define FRAME_DESER_STATS_EN to add good_frames_o / sync_errs_o counters.
module frame_deserializer
   import frame_deser_pkg::*;
#(
   parameter int                DATA_W       = 8,
   parameter int                SYNC_W       = 8,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEFAULT_SYNC_PATTERN),
   parameter int                FRAME_LEN    = 16,
   parameter int                MISS_MAX     = 3
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               data_i,
   output logic [DATA_W-1:0]  data_o,
   output logic               valid_o,
   output logic               sof_o,
   output logic               locked_o,
   output logic               sync_err_o
`ifdef FRAME_DESER_STATS_EN
   ,
   output logic [STATS_W-1:0] good_frames_o,
   output logic [STATS_W-1:0] sync_errs_o
`endif
);

   localparam int BIT_W  = cnt_w(max_int(DATA_W, SYNC_W));
   localparam int WORD_W = cnt_w(FRAME_LEN);
   localparam int MISS_W = cnt_w(MISS_MAX + 1);

   localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  SYNC_LAST  = BIT_W'(SYNC_W - 1);
   localparam logic [WORD_W-1:0] FRAME_LAST = WORD_W'(FRAME_LEN - 1);
   localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MISS_MAX);

   state_t              state_q,    state_d;
   logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
   logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
   logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
   logic [DATA_W-2:0]   wr_q,       wr_d;
   logic [DATA_W-1:0]   data_q,     data_d;
   logic                valid_q,    valid_d;
   logic                sof_q,      sof_d;
   logic                locked_q,   locked_d;
   logic                sync_err_q, sync_err_d;

   logic                sync_match;
   logic                sync_clear;
   logic [DATA_W-1:0]   word_next;
   logic [MISS_W-1:0]   miss_inc;

   sync_detector #(
      .SYNC_W       (SYNC_W),
      .SYNC_PATTERN (SYNC_PATTERN)
   ) u_sync_detector (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clear_i (sync_clear),
      .bit_i   (data_i),
      .match_o (sync_match)
   );

   assign word_next = {wr_q, data_i};
   assign miss_inc  = miss_cnt_q + MISS_W'(1);

   // Next-state logic: sync hunting, payload assembly and flywheel sync checking.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      miss_cnt_d = miss_cnt_q;
      wr_d       = wr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      sof_d      = 1'b0;
      locked_d   = locked_q;
      sync_err_d = 1'b0;
      sync_clear = 1'b0;

      unique case (state_q)
         HUNT: begin
            if (sync_match) begin
               state_d    = PAYLOAD;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               miss_cnt_d = '0;
               locked_d   = 1'b1;
            end
         end

         PAYLOAD: begin
            wr_d = word_next[DATA_W-2:0];
            if (bit_cnt_q == DATA_LAST) begin
               data_d    = word_next;
               valid_d   = 1'b1;
               sof_d     = (word_cnt_q == '0);
               bit_cnt_d = '0;
               if (word_cnt_q == FRAME_LAST) begin
                  state_d = CHECK;
               end else begin
                  word_cnt_d = word_cnt_q + WORD_W'(1);
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end

         CHECK: begin
            if (bit_cnt_q == SYNC_LAST) begin
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               if (sync_match) begin
                  miss_cnt_d = '0;
                  state_d    = PAYLOAD;
               end else begin
                  sync_err_d = 1'b1;
                  miss_cnt_d = miss_inc;
                  if (miss_inc == MISS_LIMIT) begin
                     // Too many misses in a row: alignment is gone, restart the hunt cleanly.
                     state_d    = HUNT;
                     locked_d   = 1'b0;
                     sync_clear = 1'b1;
                  end else begin
                     state_d = PAYLOAD;
                  end
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end

         default: begin
            state_d  = HUNT;
            locked_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any partial word without a strobe.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= HUNT;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         miss_cnt_q <= '0;
         wr_q       <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         locked_q   <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         wr_q       <= wr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         locked_q   <= locked_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign sof_o      = sof_q;
   assign locked_o   = locked_q;
   assign sync_err_o = sync_err_q;

`ifdef FRAME_DESER_STATS_EN
   logic [STATS_W-1:0] good_frames_q;
   logic [STATS_W-1:0] sync_errs_q;
   logic               check_last;

   assign check_last = (state_q == CHECK) && (bit_cnt_q == SYNC_LAST);

   // Saturating counts of good in-lock sync words and of sync error pulses.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         good_frames_q <= '0;
         sync_errs_q   <= '0;
      end else begin
         if (check_last && sync_match && (good_frames_q != '1)) begin
            good_frames_q <= good_frames_q + STATS_W'(1);
         end
         if (check_last && !sync_match && (sync_errs_q != '1)) begin
            sync_errs_q <= sync_errs_q + STATS_W'(1);
         end
      end
   end

   assign good_frames_o = good_frames_q;
   assign sync_errs_o   = sync_errs_q;
`endif

endmodule

// File: tb/tb_frame_deserializer.sv
// tb_frame_deserializer: table-driven frame stimulus with a scoreboard of
// expected words and sync-error pulses, plus hand-written sequences for
// reset mid-word and an end-to-end scrambler/descrambler path.
`timescale 1ns/1ps
module tb_frame_deserializer;

   localparam int DATA_W    = 8;
   localparam int SYNC_W    = 8;
   localparam int FRAME_LEN = 4;
   localparam int MISS_MAX  = 3;

   logic       clk = 1'b0;
   logic       rstn_i = 1'b0;
   logic       data_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       sof_o;
   logic       locked_o;
   logic       sync_err_o;
`ifdef FRAME_DESER_STATS_EN
   logic [15:0] good_frames;
   logic [15:0] sync_errs;
`endif

   always #5 clk = ~clk;

   frame_deserializer #(
      .DATA_W       (DATA_W),
      .SYNC_W       (SYNC_W),
      .SYNC_PATTERN (8'hD5),
      .FRAME_LEN    (FRAME_LEN),
      .MISS_MAX     (MISS_MAX)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .sof_o      (sof_o),
      .locked_o   (locked_o),
      .sync_err_o (sync_err_o)
`ifdef FRAME_DESER_STATS_EN
      ,
      .good_frames_o (good_frames),
      .sync_errs_o   (sync_errs)
`endif
   );

   typedef struct {
      logic [7:0] data;
      logic       sof;
      int         cyc;
   } exp_word_t;

   typedef struct {
      logic [7:0] sync;
      logic [7:0] words [4];
      logic       deliver;
      logic       err;
      logic       pre_locked;
      logic       post_locked;
   } frame_t;

   exp_word_t  word_q [$];
   int         err_q  [$];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [6:0] scr = 7'h5A;
   logic [6:0] dsc = 7'h00;
   frame_t     tbl [10];

   // Cycle counter used to time-stamp expected strobes.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each strobe, flags anything unexpected.
   always @(posedge clk) begin
      exp_word_t e;
      int        ec;
      #1;
      if (valid_o === 1'b1) begin
         if (word_q.size() == 0) begin
            chk("spurious_valid", valid_o, 1'b0);
         end else begin
            e = word_q.pop_front();
            $display("word: data_o=%02h sof_o=%b cycle=%0d", data_o, sof_o, cyc);
            chk("word_data", data_o, e.data);
            chk("word_sof", sof_o, e.sof);
            chk("word_cycle", cyc, e.cyc);
         end
      end else if (sof_o === 1'b1) begin
         chk("sof_without_valid", sof_o, 1'b0);
      end
      if (sync_err_o === 1'b1) begin
         if (err_q.size() == 0) begin
            chk("spurious_sync_err", sync_err_o, 1'b0);
         end else begin
            ec = err_q.pop_front();
            $display("sync_err: locked_o=%b cycle=%0d", locked_o, cyc);
            chk("sync_err_cycle", cyc, ec);
         end
      end
   end

   // Safety net: the run must always end.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      data_i = b;
      @(posedge clk);
      #1;
   endtask

   // Scrambler (x^7+x^6+1, self-synchronising) feeding a descrambler, then the DUT.
   task automatic send_scrambled(input logic d);
      logic s;
      s   = d ^ scr[6] ^ scr[5];
      scr = {scr[5:0], s};
      send_bit(s ^ dsc[6] ^ dsc[5]);
      dsc = {dsc[5:0], s};
   endtask

   task automatic send_any(input logic b, input logic scrambled);
      if (scrambled) send_scrambled(b);
      else           send_bit(b);
   endtask

   task automatic send_frame(input frame_t f, input logic scrambled);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) begin
            chk("locked_before_sync", locked_o, f.pre_locked);
            if (f.err) err_q.push_back(cyc + 1);
         end
         send_any(f.sync[i], scrambled);
      end
      chk("locked_after_sync", locked_o, f.post_locked);
      for (int w = 0; w < FRAME_LEN; w++) begin
         for (int i = 7; i >= 0; i--) begin
            if (i == 0 && f.deliver) word_q.push_back('{f.words[w], (w == 0), cyc + 1});
            send_any(f.words[w][i], scrambled);
         end
      end
   endtask

   initial begin
      logic [7:0] sh;
      logic [7:0] sync_v;
      logic       b;
      frame_t     e2e;

      // sync, payload, deliver, err, locked before last sync bit, locked after
      tbl[0] = '{8'hD5, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b1, 1'b0, 1'b0, 1'b1}; // acquire
      tbl[1] = '{8'hD5, '{8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0, 1'b1, 1'b1}; // steady
      tbl[2] = '{8'hD5, '{8'h05, 8'h06, 8'h07, 8'h08}, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{8'hD5, '{8'h09, 8'h0A, 8'h0B, 8'h0C}, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{8'hD4, '{8'h61, 8'h62, 8'h63, 8'h64}, 1'b1, 1'b1, 1'b1, 1'b1}; // flywheel
      tbl[5] = '{8'hD5, '{8'h71, 8'h72, 8'h73, 8'h74}, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{8'h00, '{8'h81, 8'h82, 8'h83, 8'h84}, 1'b1, 1'b1, 1'b1, 1'b1}; // miss 1
      tbl[7] = '{8'h55, '{8'h91, 8'h92, 8'h93, 8'h94}, 1'b1, 1'b1, 1'b1, 1'b1}; // miss 2
      tbl[8] = '{8'hF5, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b1, 1'b0}; // miss 3: lock lost
      tbl[9] = '{8'hD5, '{8'h5A, 8'hA5, 8'h3C, 8'hC3}, 1'b1, 1'b0, 1'b0, 1'b1}; // reacquire
      e2e    = '{8'hD5, '{8'hA0, 8'hB1, 8'hC2, 8'hE3}, 1'b1, 1'b0, 1'b0, 1'b1};
      sync_v = 8'hD5;

      // Reset state
      rstn_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_o", data_o, 8'h00);
      chk("rst_valid_o", valid_o, 1'b0);
      chk("rst_sof_o", sof_o, 1'b0);
      chk("rst_locked_o", locked_o, 1'b0);
      chk("rst_sync_err_o", sync_err_o, 1'b0);
      rstn_i = 1'b1;

      // 20 random idle bits that never form the sync word (including across into it)
      sh = 8'h00;
      for (int i = 0; i < 20; i++) begin
         b = 1'($urandom_range(0, 1));
         if (i == 19) b = 1'b1;
         if ({sh[6:0], b} == sync_v) b = ~b;
         sh = {sh[6:0], b};
         send_bit(b);
      end
      chk("locked_idle", locked_o, 1'b0);

      // Table-driven frames: acquire, steady lock, flywheel, loss, reacquire
      for (int f = 0; f < 10; f++) begin
         $display("frame %0d: sync=%02h", f, tbl[f].sync);
         send_frame(tbl[f], 1'b0);
      end

      // Good in-lock sync, then reset after 5 payload bits
      for (int i = 7; i >= 0; i--) send_bit(sync_v[i]);
      chk("locked_before_reset", locked_o, 1'b1);
`ifdef FRAME_DESER_STATS_EN
      chk("good_frames", good_frames, 16'd5);
      chk("sync_errs", sync_errs, 16'd4);
`endif
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      rstn_i = 1'b0;
      @(posedge clk);
      #1;
      $display("reset mid-word: data_o=%02h locked_o=%b", data_o, locked_o);
      chk("midrst_data_o", data_o, 8'h00);
      chk("midrst_valid_o", valid_o, 1'b0);
      chk("midrst_sof_o", sof_o, 1'b0);
      chk("midrst_locked_o", locked_o, 1'b0);
      chk("midrst_sync_err_o", sync_err_o, 1'b0);
      rstn_i = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      chk("hunt_after_reset", locked_o, 1'b0);

      // End-to-end through scrambler and descrambler
      for (int i = 0; i < 24; i++) send_scrambled(1'b0);
      chk("locked_e2e_preamble", locked_o, 1'b0);
      $display("frame e2e: sync=%02h", e2e.sync);
      send_frame(e2e, 1'b1);

      repeat (3) @(posedge clk);
      #2;
      chk("pending_words", word_q.size(), 0);
      chk("pending_sync_errs", err_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
